// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// The owner encoding identifies which requester a pending response belongs to.
package imem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic {NORMAL, LOCKED} state_e;

  typedef enum logic {OWN_F, OWN_L} owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
    logic   we;
  } rsp_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface imem_arbiter_if #(parameter int AW = 8);

  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          f_err;

  logic          l_req;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_lock;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          l_err;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, m_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
           l_gnt, l_rvalid, l_rdata, l_err,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
           l_gnt, l_rvalid, l_rdata, l_err,
           m_en, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/imem_arbiter_rr_pick.sv
// Two-way round-robin picker: bit 0 is fetch, bit 1 is loader.
// On contention the requester that was not granted last wins; mask_f removes fetch.
module imem_rr_pick
  import imem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  input  logic       mask_f,
  output logic [1:0] gnt
);

  logic [1:0] req_eff;

  always_comb begin
    req_eff = {req[1], req[0] & ~mask_f};
    gnt     = 2'b00;
    case (req_eff)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == OWN_L) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port synchronous instruction memory between fetch and loader,
// with a loader lock, alignment/range checking and response routing.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter int          AW       = 8,
  parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
) (
  input  logic           clk,
  input  logic           rst,
  imem_arbiter_if.slave  bus
);

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  state_e      state_q, state_d;
  owner_e      last_q, last_d;
  rsp_t        rsp_q, rsp_d;
  logic [1:0]  req_v;
  logic [1:0]  gnt;
  logic [31:0] sel_addr;
  logic        legal;
  logic        any_gnt;
  logic        f_hit;
  logic        l_hit;
  logic [31:0] rsp_data;

  // Requests are masked during reset so every output reads zero.
  always_comb begin
    req_v = rst ? 2'b00 : {bus.l_req, bus.f_req};
  end

  imem_rr_pick u_pick (
    .req    (req_v),
    .last   (last_q),
    .mask_f (bus.l_lock),
    .gnt    (gnt)
  );

  always_comb begin
    any_gnt  = |gnt;
    sel_addr = gnt[1] ? bus.l_addr : bus.f_addr;
    legal    = (sel_addr[1:0] == 2'b00) && (sel_addr < ADDR_LIMIT);

    bus.f_gnt   = gnt[0];
    bus.l_gnt   = gnt[1];
    bus.m_en    = any_gnt & legal;
    bus.m_we    = any_gnt & legal & gnt[1] & bus.l_we;
    bus.m_addr  = bus.m_en ? sel_addr[AW+1:2] : '0;
    bus.m_wdata = bus.m_we ? bus.l_wdata : '0;

    state_d = bus.l_lock ? LOCKED : NORMAL;

    // Leaving lock hands the next contest to fetch regardless of this cycle's grant.
    last_d = last_q;
    if (gnt[1]) begin
      last_d = OWN_L;
    end else if (gnt[0]) begin
      last_d = OWN_F;
    end
    if ((state_q == LOCKED) && !bus.l_lock) begin
      last_d = OWN_L;
    end

    rsp_d.valid = any_gnt;
    rsp_d.owner = gnt[1] ? OWN_L : OWN_F;
    rsp_d.err   = ~legal;
    rsp_d.we    = gnt[1] & bus.l_we;
  end

  always_comb begin
    if (rsp_q.we) begin
      rsp_data = '0;
    end else if (rsp_q.err) begin
      rsp_data = NOP_WORD;
    end else begin
      rsp_data = bus.m_rdata;
    end

    f_hit = rsp_q.valid && (rsp_q.owner == OWN_F) && !rst;
    l_hit = rsp_q.valid && (rsp_q.owner == OWN_L) && !rst;

    bus.f_rvalid = f_hit;
    bus.f_rdata  = f_hit ? rsp_data : '0;
    bus.f_err    = f_hit & rsp_q.err;
    bus.l_rvalid = l_hit;
    bus.l_rdata  = l_hit ? rsp_data : '0;
    bus.l_err    = l_hit & rsp_q.err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      last_q  <= OWN_L;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rsp_q   <= rsp_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed and randomized bench for imem_arbiter against a transaction-level model
// of grants, memory contents and pending responses.
module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  imem_arbiter_if #(.AW(AW)) bus ();

  imem_arbiter #(.DEPTH(DEPTH), .AW(AW), .NOP_WORD(NOP_WORD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous single-port memory with one cycle of read latency.
  logic [31:0] mem [DEPTH] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
      bus.m_rdata <= mem[bus.m_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit          mdl_last_l = 1'b1;
  bit          mdl_locked = 1'b0;
  bit          p_valid    = 1'b0;
  bit          p_own_l, p_err, p_we;
  logic [31:0] p_data;
  logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};

  bit          e_gf, e_gl, e_legal;
  logic [31:0] e_addr;

  logic        o_f_gnt, o_l_gnt, o_m_en, o_m_we;
  logic        o_f_rvalid, o_l_rvalid, o_f_err, o_l_err;
  logic [31:0] o_f_rdata, o_l_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    bit ff, e_men, e_mwe, e_frv, e_lrv;
    e_gf = 1'b0;
    e_gl = 1'b0;
    if (!rst) begin
      ff = bus.f_req && !bus.l_lock;
      if (ff && bus.l_req) begin
        if (mdl_last_l) e_gf = 1'b1;
        else            e_gl = 1'b1;
      end else if (ff) begin
        e_gf = 1'b1;
      end else if (bus.l_req) begin
        e_gl = 1'b1;
      end
    end
    e_addr  = e_gl ? bus.l_addr : bus.f_addr;
    e_legal = (e_addr % 4 == 0) && (e_addr < 32'(DEPTH * 4));
    e_men   = (e_gf || e_gl) && e_legal;
    e_mwe   = e_men && e_gl && bus.l_we;
    e_frv   = !rst && p_valid && !p_own_l;
    e_lrv   = !rst && p_valid && p_own_l;

    check("f_gnt",    32'(bus.f_gnt),    32'(e_gf));
    check("l_gnt",    32'(bus.l_gnt),    32'(e_gl));
    check("m_en",     32'(bus.m_en),     32'(e_men));
    check("m_we",     32'(bus.m_we),     32'(e_mwe));
    if (e_men)     check("m_addr",  32'(bus.m_addr), 32'(e_addr[9:2]));
    else if (rst)  check("m_addr0", 32'(bus.m_addr), 32'h0);
    if (e_mwe)     check("m_wdata", bus.m_wdata, bus.l_wdata);
    else if (rst)  check("m_wdata0", bus.m_wdata, 32'h0);
    check("f_rvalid", 32'(bus.f_rvalid), 32'(e_frv));
    check("l_rvalid", 32'(bus.l_rvalid), 32'(e_lrv));
    check("f_err",    32'(bus.f_err),    32'(e_frv && p_err));
    check("l_err",    32'(bus.l_err),    32'(e_lrv && p_err));
    if (e_frv)     check("f_rdata",  bus.f_rdata, p_data);
    else if (rst)  check("f_rdata0", bus.f_rdata, 32'h0);
    if (e_lrv)     check("l_rdata",  bus.l_rdata, p_data);
    else if (rst)  check("l_rdata0", bus.l_rdata, 32'h0);

    o_f_gnt = bus.f_gnt;  o_l_gnt = bus.l_gnt;  o_m_en = bus.m_en;  o_m_we = bus.m_we;
    o_f_rvalid = bus.f_rvalid;  o_l_rvalid = bus.l_rvalid;
    o_f_err = bus.f_err;  o_l_err = bus.l_err;
    o_f_rdata = bus.f_rdata;  o_l_rdata = bus.l_rdata;
  endtask

  task automatic update_model();
    if (rst) begin
      mdl_last_l = 1'b1;
      mdl_locked = 1'b0;
      p_valid    = 1'b0;
    end else begin
      p_valid = e_gf || e_gl;
      p_own_l = e_gl;
      p_err   = !e_legal;
      p_we    = e_gl && bus.l_we;
      if (p_we)          p_data = 32'h0;
      else if (!e_legal) p_data = NOP_WORD;
      else               p_data = ref_mem[e_addr[9:2]];
      if (p_valid && e_legal && p_we) ref_mem[e_addr[9:2]] = bus.l_wdata;
      if (p_valid) mdl_last_l = e_gl;
      if (mdl_locked && !bus.l_lock) mdl_last_l = 1'b1;
      mdl_locked = bus.l_lock;
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic fr, input logic [31:0] fa,
                                input logic lr, input logic lwe, input logic [31:0] la,
                                input logic [31:0] lwd, input logic lk);
    @(negedge clk);
    rst         = r;
    bus.f_req   = fr;
    bus.f_addr  = fa;
    bus.l_req   = lr;
    bus.l_we    = lwe;
    bus.l_addr  = la;
    bus.l_wdata = lwd;
    bus.l_lock  = lk;
    #1;
    check_output();
    update_model();
  endtask

  task automatic idle(input logic r);
    apply_stimulus(r, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return $urandom;
    if (sel == 1) return 32'(($urandom_range(0, 63) << 2) | 1);
    return 32'($urandom_range(0, 31) * 4);
  endfunction

  logic [31:0] seq_data [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  initial begin
    logic lk_r;
    idle(1'b1);
    apply_stimulus(1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 32'h5, 1'b0);
    check("reset_f_gnt", 32'(o_f_gnt), 32'h0);
    check("reset_m_en",  32'(o_m_en),  32'h0);

    // Load the first four words through the loader port.
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(i * 4), seq_data[i], 1'b0);
    idle(1'b0);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, i < 4, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      if (i < 4) check("seq_gnt", 32'(o_f_gnt), 32'h1);
      if (i > 0) check("seq_rdata", o_f_rdata, seq_data[i-1]);
    end

    // Contention after reset must start with fetch and alternate.
    idle(1'b1);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      check("rr_f_gnt", 32'(o_f_gnt), 32'(i % 2 == 0));
      check("rr_l_gnt", 32'(o_l_gnt), 32'(i % 2 == 1));
      if (i > 0 && (i % 2 == 1)) check("rr_f_route", o_f_rdata, 32'h11);
      if (i > 0 && (i % 2 == 0)) check("rr_l_route", o_l_rdata, 32'h22);
    end
    idle(1'b0);

    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    check("lock_f_gnt", 32'(o_f_gnt), 32'h0);
    check("lock_l_gnt", 32'(o_l_gnt), 32'h1);
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("lock_f_gnt2", 32'(o_f_gnt), 32'h0);
    check("lock_wr_rvalid", 32'(o_l_rvalid), 32'h1);
    check("lock_wr_rdata", o_l_rdata, 32'h0);
    idle(1'b0);
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check("unlock_f_first", 32'(o_f_gnt), 32'h1);
    idle(1'b0);
    check("unlock_f_rdata", o_f_rdata, 32'hDEADBEEF);

    apply_stimulus(1'b0, 1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("mis_gnt", 32'(o_f_gnt), 32'h1);
    check("mis_m_en", 32'(o_m_en), 32'h0);
    apply_stimulus(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("oor_m_en", 32'(o_m_en), 32'h0);
    check("mis_err", 32'(o_f_err), 32'h1);
    check("mis_nop", o_f_rdata, 32'h13);
    idle(1'b0);
    check("oor_err", 32'(o_f_err), 32'h1);
    check("oor_nop", o_f_rdata, 32'h13);

    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h402, 32'h12345678, 1'b0);
    check("ilw_m_en", 32'(o_m_en), 32'h0);
    idle(1'b0);
    check("ilw_err", 32'(o_l_err), 32'h1);
    check("ilw_mem0", mem[0], 32'h11);

    apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("rst_no_rvalid", 32'(o_f_rvalid), 32'h0);
    apply_stimulus(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    check("rst_f_first", 32'(o_f_gnt), 32'h1);
    check("rst_no_rvalid2", 32'(o_f_rvalid), 32'h0);

    lk_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) lk_r = ~lk_r;
      apply_stimulus($urandom_range(0, 49) == 0, 1'($urandom), rand_addr(),
                     1'($urandom), 1'($urandom), rand_addr(), $urandom, lk_r);
    end
    idle(1'b0);
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
